// File: rtl/if_de_pipeline_reg.sv
// Fetch-to-decode pipeline register with load-use stall skid buffer and branch flush.
// Owns the PC_write / DE-EX bubble handshake and a saturating stall-cycle counter.
module if_de_pipeline_reg #(
  parameter int unsigned XLEN  = 32,
  parameter logic [31:0] NOP   = 32'h0000_0013,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      imem_dout,
  input  logic             loadUse,
  input  logic             flush,
  output logic [XLEN-1:0]  de_pc,
  output logic [XLEN-1:0]  de_pc4,
  output logic [31:0]      de_instr,
  output logic             de_valid,
  output logic             PC_write,
  output logic             de_ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] skid;
  logic        stall;

  // flush wins over loadUse; a hazard against an empty slot is meaningless
  assign stall = loadUse & de_valid & ~flush;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    PC_write     = 1'b1;
    de_ex_bubble = 1'b0;
    de_instr     = NOP;
    if (de_valid) de_instr = (state == HOLD) ? skid : imem_dout;
    if (flush) begin
      de_ex_bubble = 1'b1;
      state_nxt    = RUN;
    end else if (stall) begin
      PC_write     = 1'b0;
      de_ex_bubble = 1'b1;
      state_nxt    = HOLD;
    end else begin
      state_nxt    = RUN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      de_pc       <= '0;
      de_pc4      <= XLEN'(4);
      de_valid    <= 1'b0;
      skid        <= NOP;
      stall_count <= '0;
    end else if (flush) begin
      de_pc    <= if_pc;
      de_pc4   <= if_pc + XLEN'(4);
      de_valid <= 1'b0;
      skid     <= NOP;
    end else if (stall) begin
      // imem_dout only still shows the decode instruction on the first stall cycle
      if (state == RUN) skid <= imem_dout;
      if (stall_count != '1) stall_count <= stall_count + 1'b1;
    end else begin
      de_pc    <= if_pc;
      de_pc4   <= if_pc + XLEN'(4);
      de_valid <= 1'b1;
    end
  end

endmodule
